// File: rtl/i2c_xfer_scheduler.sv
// i2c_xfer_scheduler: round-robin transaction scheduler in front of a byte-level I2C command interface
module i2c_xfer_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]                  req_op_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]        req_len_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    input  logic [I2C_DATA_WIDTH-1:0]           wdata_i,
    output logic                                wdata_rd_o,
    output logic [I2C_DATA_WIDTH-1:0]           rdata_o,
    output logic                                rdata_vld_o,
    output logic [NUM_REQ-1:0]                  done_o,
    output logic [1:0]                          status_o,
    output logic                                busy_o,
    output logic [2:0]                          bc_cmd_o,
    output logic [I2C_DATA_WIDTH-1:0]           bc_data_o,
    output logic                                bc_req_o,
    input  logic                                bc_done_i,
    input  logic                                bc_nak_i,
    input  logic                                bc_al_i,
    input  logic [I2C_DATA_WIDTH-1:0]           bc_data_i
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_STOP = 3'd4, S_DONE = 3'd5;
    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_RACK = 3'd2, C_RNAK = 3'd3, C_WRITE = 3'd4;

    logic [2:0]                r_state;
    logic [IW-1:0]             r_idx;
    logic [IW-1:0]             r_ptr;
    logic [I2C_ADDR_WIDTH-1:0] r_addr;
    logic                      r_op;
    logic [LEN_WIDTH-1:0]      r_cnt;
    logic [NUM_REQ-1:0]        r_gnt;
    logic                      r_busy;
    logic                      r_bc_req;
    logic [2:0]                r_bc_cmd;
    logic [I2C_DATA_WIDTH-1:0] r_bc_data;
    logic                      r_wdata_rd;
    logic [I2C_DATA_WIDTH-1:0] r_rdata;
    logic                      r_rdata_vld;
    logic [NUM_REQ-1:0]        r_done;
    logic [1:0]                r_status;
    logic [IW-1:0]             w_pick;
    logic [IW-1:0]             w_j;
    logic                      w_any;

    assign gnt_o       = r_gnt;
    assign busy_o      = r_busy;
    assign bc_req_o    = r_bc_req;
    assign bc_cmd_o    = r_bc_cmd;
    assign bc_data_o   = r_bc_data;
    assign wdata_rd_o  = r_wdata_rd;
    assign rdata_o     = r_rdata;
    assign rdata_vld_o = r_rdata_vld;
    assign done_o      = r_done;
    assign status_o    = r_status;

    // Round-robin search upward from the pointer; the lowest offset that is requesting wins
    always_comb begin
        w_pick = r_ptr;
        w_any  = 1'b0;
        w_j    = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (req_i[w_j]) begin
                w_pick = w_j;
                w_any  = 1'b1;
            end
        end
    end

    // Transaction sequencer: grant, issue one command per state, react to each command completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_addr      <= '0;
            r_op        <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_bc_req    <= 1'b0;
            r_bc_cmd    <= '0;
            r_bc_data   <= '0;
            r_wdata_rd  <= 1'b0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
            r_done      <= '0;
            r_status    <= '0;
        end else begin
            r_wdata_rd  <= 1'b0;
            r_rdata_vld <= 1'b0;
            r_done      <= '0;
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_idx    <= w_pick;
                    r_addr   <= I2C_ADDR_WIDTH'(req_addr_i >> (int'(w_pick) * I2C_ADDR_WIDTH));
                    r_op     <= req_op_i[w_pick];
                    r_cnt    <= LEN_WIDTH'(req_len_i >> (int'(w_pick) * LEN_WIDTH));
                    r_status <= 2'b00;
                    r_state  <= S_START;
                end
            end else if (r_state == S_DONE) begin
                r_gnt   <= '0;
                r_busy  <= 1'b0;
                r_ptr   <= (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + 1'b1;
                r_state <= S_IDLE;
            end else if (!r_bc_req) begin
                r_bc_req   <= 1'b1;
                r_gnt      <= NUM_REQ'(1) << r_idx;
                r_busy     <= 1'b1;
                r_bc_cmd   <= (r_state == S_START) ? C_START :
                              (r_state == S_STOP)  ? C_STOP  :
                              (r_state == S_DATA && r_op) ? ((r_cnt > LEN_WIDTH'(1)) ? C_RACK : C_RNAK) : C_WRITE;
                r_bc_data  <= (r_state == S_ADDR) ? I2C_DATA_WIDTH'({r_addr, r_op}) :
                              (r_state == S_DATA && !r_op) ? wdata_i : '0;
                r_wdata_rd <= (r_state == S_DATA) && !r_op;
            end else if (bc_done_i) begin
                r_bc_req <= 1'b0;
                if (bc_al_i) begin
                    r_status <= 2'b11;
                    r_done   <= r_gnt;
                    r_state  <= S_DONE;
                end else if (r_state == S_START) begin
                    r_state <= S_ADDR;
                end else if (r_state == S_ADDR) begin
                    r_status <= bc_nak_i ? 2'b01 : 2'b00;
                    r_state  <= (bc_nak_i || r_cnt == '0) ? S_STOP : S_DATA;
                end else if (r_state == S_DATA) begin
                    if (!r_op && bc_nak_i) begin
                        r_status <= 2'b10;
                        r_state  <= S_STOP;
                    end else begin
                        r_cnt       <= r_cnt - 1'b1;
                        r_rdata_vld <= r_op;
                        if (r_op) r_rdata <= bc_data_i;
                        if (r_cnt == LEN_WIDTH'(1)) r_state <= S_STOP;
                    end
                end else begin
                    r_done  <= r_gnt;
                    r_state <= S_DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_xfer_scheduler.sv
// tb_i2c_xfer_scheduler: randomized transactions checked against a command-list reference model
module tb_i2c_xfer_scheduler;
    localparam int NR = 2, AW = 7, DW = 8, LW = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NR-1:0] req_i = '0, req_op_i = '0;
    logic [NR*AW-1:0] req_addr_i = '0;
    logic [NR*LW-1:0] req_len_i = '0;
    logic [DW-1:0] wdata_i = '0, bc_data_i = '0;
    logic bc_done_i = 1'b0, bc_nak_i = 1'b0, bc_al_i = 1'b0;
    logic [NR-1:0] gnt_o, done_o;
    logic wdata_rd_o, rdata_vld_o, busy_o, bc_req_o;
    logic [DW-1:0] rdata_o, bc_data_o;
    logic [1:0] status_o;
    logic [2:0] bc_cmd_o;

    i2c_xfer_scheduler #(.NUM_REQ(NR), .I2C_ADDR_WIDTH(AW), .I2C_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_addr_i(req_addr_i), .req_op_i(req_op_i),
        .req_len_i(req_len_i), .gnt_o(gnt_o), .wdata_i(wdata_i), .wdata_rd_o(wdata_rd_o),
        .rdata_o(rdata_o), .rdata_vld_o(rdata_vld_o), .done_o(done_o), .status_o(status_o),
        .busy_o(busy_o), .bc_cmd_o(bc_cmd_o), .bc_data_o(bc_data_o), .bc_req_o(bc_req_o),
        .bc_done_i(bc_done_i), .bc_nak_i(bc_nak_i), .bc_al_i(bc_al_i), .bc_data_i(bc_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cidx = 0, nak_at = -1, al_at = -1, wait_cnt = 0;
    logic [10:0] obs_cmd[$];
    logic [7:0] exp_rd[$], obs_rd[$], wbytes[$], wfix[$];
    logic [10:0] exp_e[$];
    int wrd_cnt = 0, wptr = 0, last_hs = -1, exp_r = 0, exp_wrd = 0, rr_ptr = 0;
    logic [1:0] exp_sts;
    logic [NR-1:0] done_val, exp_gnt = '0;
    logic [1:0] done_sts;
    bit done_seen = 0;
    logic prev_req = 1'b0, prev_hs = 1'b0;
    logic [2:0] prev_cmd;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_gnt"}, 32'(gnt_o), 0);
        chk({p, "_busy"}, 32'(busy_o), 0);
        chk({p, "_bc_req"}, 32'(bc_req_o), 0);
        chk({p, "_bc_cmd"}, 32'(bc_cmd_o), 0);
        chk({p, "_bc_data"}, 32'(bc_data_o), 0);
        chk({p, "_wdata_rd"}, 32'(wdata_rd_o), 0);
        chk({p, "_rdata"}, 32'(rdata_o), 0);
        chk({p, "_rdata_vld"}, 32'(rdata_vld_o), 0);
        chk({p, "_done"}, 32'(done_o), 0);
        chk({p, "_status"}, 32'(status_o), 0);
    endtask

    // Bus responder: answers each command after a random delay, injecting NAK/AL at chosen command indices
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            bc_done_i = 1'b0;
            bc_nak_i  = 1'b0;
            bc_al_i   = 1'b0;
            if (rst_n && bc_req_o) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    bc_done_i = 1'b1;
                    bc_nak_i  = (cidx == nak_at);
                    bc_al_i   = (cidx == al_at);
                    bc_data_i = 8'($urandom);
                    obs_cmd.push_back({bc_cmd_o, (bc_cmd_o == 3'd4) ? bc_data_o : 8'h00});
                    if ((bc_cmd_o == 3'd2 || bc_cmd_o == 3'd3) && !bc_al_i) exp_rd.push_back(bc_data_i);
                    cidx++;
                    wait_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    // Monitor: protocol checks mid-cycle, write-data supply, read-data and completion capture
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_hs  = -1;
                prev_req = 1'b0;
                prev_hs  = 1'b0;
            end else begin
                chk("gnt_onehot0", 32'($onehot0(gnt_o)), 1);
                if (bc_req_o && !prev_req) begin
                    chk("grant", 32'(gnt_o), 32'(exp_gnt));
                    chk("busy_during", 32'(busy_o), 1);
                    if (last_hs >= 0) chk("req_gap", cyc - last_hs, 2);
                end
                if (bc_req_o && prev_req && !prev_hs) begin
                    chk("hold_cmd", 32'(bc_cmd_o), 32'(prev_cmd));
                    chk("hold_data", 32'(bc_data_o), 32'(prev_data));
                end
                prev_hs = bc_req_o && bc_done_i;
                if (prev_hs) last_hs = cyc;
                prev_req  = bc_req_o;
                prev_cmd  = bc_cmd_o;
                prev_data = bc_data_o;
                if (wdata_rd_o) begin
                    wrd_cnt++;
                    wptr++;
                    wdata_i = (wptr < wbytes.size()) ? wbytes[wptr] : 8'h00;
                end
                if (rdata_vld_o) obs_rd.push_back(rdata_o);
                if (done_o != '0) begin
                    done_seen = 1;
                    done_val  = done_o;
                    done_sts  = status_o;
                    last_hs   = -1;
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic op, input logic [LW-1:0] len);
        req_addr_i = (req_addr_i & ~({{(NR-1)*AW{1'b0}}, {AW{1'b1}}} << (r * AW))) | ({{(NR-1)*AW{1'b0}}, a} << (r * AW));
        req_len_i  = (req_len_i & ~({{(NR-1)*LW{1'b0}}, {LW{1'b1}}} << (r * LW))) | ({{(NR-1)*LW{1'b0}}, len} << (r * LW));
        req_op_i   = op ? (req_op_i | (NR'(1) << r)) : (req_op_i & ~(NR'(1) << r));
    endtask

    // Reference model: pick the winner, then list the full command series the transaction must produce
    task automatic prep(input logic [NR-1:0] raise, input int nak, input int al);
        logic [NR-1:0] m;
        logic [AW-1:0] a;
        logic op;
        int len;
        m = req_i | raise;
        exp_r = -1;
        for (int k = 0; k < NR; k++)
            if (exp_r < 0 && (m & (NR'(1) << ((rr_ptr + k) % NR))) != '0) exp_r = (rr_ptr + k) % NR;
        a   = AW'(req_addr_i >> (exp_r * AW));
        op  = ((req_op_i >> exp_r) & NR'(1)) != '0;
        len = int'(LW'(req_len_i >> (exp_r * LW)));
        wbytes.delete();
        for (int b = 0; b < len; b++) wbytes.push_back((wfix.size() == len) ? wfix[b] : 8'($urandom));
        wfix.delete();
        wptr = 0;
        wdata_i = (len > 0) ? wbytes[0] : 8'h00;
        exp_e.delete();
        exp_e.push_back({3'd0, 8'h00});
        exp_e.push_back({3'd4, a, op});
        exp_sts = 2'b00;
        if (nak == 1) exp_sts = 2'b01;
        else for (int b = 0; b < len && exp_sts == 2'b00; b++) begin
            exp_e.push_back(op ? {(b < len - 1) ? 3'd2 : 3'd3, 8'h00} : {3'd4, wbytes[b]});
            if (!op && nak == b + 2) exp_sts = 2'b10;
        end
        exp_e.push_back({3'd1, 8'h00});
        if (al >= 0 && al < exp_e.size()) begin
            while (exp_e.size() > al + 1) void'(exp_e.pop_back());
            exp_sts = 2'b11;
        end
        exp_wrd = 0;
        for (int i = 2; i < exp_e.size(); i++) if (exp_e[i][10:8] == 3'd4) exp_wrd++;
        cidx = 0; nak_at = nak; al_at = al; wait_cnt = 0;
        obs_cmd.delete(); exp_rd.delete(); obs_rd.delete();
        wrd_cnt = 0; done_seen = 0;
        exp_gnt = NR'(1) << exp_r;
        req_i = m;
    endtask

    task automatic run_one(input string tn, input logic [NR-1:0] raise, input int nak, input int al);
        prep(raise, nak, al);
        for (int t = 0; t < 4000 && !done_seen; t++) begin
            @(posedge clk);
            #2;
        end
        chk({tn, "_done_seen"}, 32'(done_seen), 1);
        req_i = req_i & ~(NR'(1) << exp_r);
        chk({tn, "_done_o"}, 32'(done_val), 32'(exp_gnt));
        chk({tn, "_status"}, 32'(done_sts), 32'(exp_sts));
        chk({tn, "_ncmd"}, obs_cmd.size(), exp_e.size());
        for (int i = 0; i < exp_e.size(); i++)
            chk($sformatf("%s_cmd%0d", tn, i), (i < obs_cmd.size()) ? 32'(obs_cmd[i]) : 32'hx, 32'(exp_e[i]));
        chk({tn, "_wdata_rd"}, wrd_cnt, exp_wrd);
        chk({tn, "_nrd"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size(); i++)
            chk($sformatf("%s_rd%0d", tn, i), (i < obs_rd.size()) ? 32'(obs_rd[i]) : 32'hx, 32'(exp_rd[i]));
        chk({tn, "_busy_after"}, 32'(busy_o), 0);
        chk({tn, "_gnt_after"}, 32'(gnt_o), 0);
        rr_ptr = (exp_r + 1) % NR;
    endtask

    initial begin : main
        logic [NR-1:0] raise;
        int len, nak, al;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        set_req(0, 7'h22, 1'b0, 8'd3);
        wfix = '{8'h11, 8'h22, 8'h33};
        run_one("write", 2'b01, -1, -1);
        set_req(1, 7'h22, 1'b1, 8'd2);
        run_one("read", 2'b10, -1, -1);
        set_req(0, 7'($urandom), 1'($urandom), 8'($urandom_range(0, 4)));
        set_req(1, 7'($urandom), 1'($urandom), 8'($urandom_range(0, 4)));
        for (int i = 0; i < 4; i++) begin
            raise = (i == 0) ? 2'b11 : (i == 3) ? 2'b00 : (NR'(1) << exp_r);
            run_one($sformatf("rr%0d", i), raise, -1, -1);
        end
        set_req(0, 7'($urandom), 1'b0, 8'd3);
        run_one("addr_nak", 2'b01, 1, -1);
        set_req(0, 7'($urandom), 1'b0, 8'd4);
        run_one("data_nak", 2'b01, 3, -1);
        set_req(1, 7'($urandom), 1'b0, 8'd3);
        run_one("arb_lost", 2'b10, -1, 2);
        set_req(0, 7'($urandom), 1'($urandom), 8'd0);
        run_one("probe", 2'b01, -1, -1);
        set_req(1, 7'($urandom), 1'b0, 8'd2);
        run_one("nak_and_al", 2'b10, 1, 1);
        set_req(0, 7'($urandom), 1'b0, 8'd2);
        run_one("al_on_stop", 2'b01, -1, 4);
        set_req(1, 7'($urandom), 1'($urandom), 8'd255);
        run_one("max_len", 2'b10, -1, -1);
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < NR; r++)
                if ((req_i & (NR'(1) << r)) == '0) set_req(r, 7'($urandom), 1'($urandom), 8'($urandom_range(0, 5)));
            raise = NR'($urandom) & ~req_i;
            if ((req_i | raise) == '0) raise = NR'(1) << $urandom_range(0, NR - 1);
            len = 7;
            nak = ($urandom_range(0, 9) < 3) ? $urandom_range(1, len) : -1;
            al  = ($urandom_range(0, 9) < 2) ? $urandom_range(0, len) : -1;
            run_one($sformatf("rand%0d", i), raise, nak, al);
        end
        while (req_i != '0) run_one("drain", 2'b00, -1, -1);
        set_req(0, 7'($urandom), 1'b0, 8'd0);
        run_one("pre_reset", 2'b01, -1, -1);
        set_req(1, 7'($urandom), 1'b1, 8'd5);
        prep(2'b10, -1, -1);
        for (int t = 0; t < 500 && obs_rd.size() == 0; t++) begin
            @(posedge clk);
            #2;
        end
        chk("reached_data", 32'(obs_rd.size() > 0), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        req_i = '0;
        rr_ptr = 0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("midrst_hold");
        rst_n = 1'b1;
        set_req(0, 7'($urandom), 1'b0, 8'd1);
        set_req(1, 7'($urandom), 1'b0, 8'd2);
        run_one("post_rst0", 2'b11, -1, -1);
        run_one("post_rst1", 2'b00, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
